alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_if.sv | 24 ++
 rtl/alu_exec_unit.sv | 134 +++++++++++++
 tb/tb_alu_exec_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle between EX-stage control and the ALU execute unit.
interface alu_exec_if #(
  parameter int DATA_W = 32
);
  logic              valid_i;
  logic [2:0]        ALUCtrl_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic              flush_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] result_o;
  logic              zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    input  ready_o, valid_o, result_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    output ready_o, valid_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ops plus an iterative shift-add multiplier that
// holds ready low while busy. Results are registered and held between completions.
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input logic       clk_i,
  input logic       rst_i,
  alu_exec_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] mcand_r, mcand_s;
  logic [DATA_W-1:0] mplier_r, mplier_s;
  logic [DATA_W-1:0] acc_r, acc_s;
  logic [DATA_W-1:0] acc_step_s;
  logic [DATA_W-1:0] result_r, result_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              valid_r, valid_s;
  logic              accept_s;

  // MUL and the undefined code both fall to zero here; MUL never uses this path.
  function automatic logic [DATA_W-1:0] single_op(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRA:  r = $signed(a) >>> b[4:0];
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

  // Flush beats a simultaneous request, so it gates acceptance.
  assign accept_s   = bus.valid_i && (state_r == ST_IDLE) && !bus.flush_i;
  assign acc_step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  // Next-state, multiplier datapath and result capture.
  always_comb begin
    state_s  = state_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    result_s = result_r;
    valid_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (bus.ALUCtrl_i == OP_MUL)) begin
          mcand_s  = bus.data1_i;
          mplier_s = bus.data2_i;
          acc_s    = {DATA_W{1'b0}};
          cnt_s    = {CNT_W{1'b0}};
          state_s  = ST_MUL;
        end else if (accept_s) begin
          result_s = single_op(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);
          valid_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (bus.flush_i) begin
          state_s = ST_IDLE;
        end else begin
          acc_s    = acc_step_s;
          mcand_s  = mcand_r << 1;
          mplier_s = mplier_r >> 1;
          cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            result_s = acc_step_s;
            valid_s  = 1'b1;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_MUL;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      result_r <= result_s;
      valid_r  <= valid_s;
    end
  end

  assign bus.ready_o  = (state_r == ST_IDLE);
  assign bus.valid_o  = valid_r;
  assign bus.result_o = result_r;
  assign bus.zero_o   = (result_r == {DATA_W{1'b0}});

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table driven through a
// latency-aware scoreboard, plus hand-written MUL stall/flush/reset sequences.
module tb_alu_exec_unit;

  localparam int DATA_W = 32;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          due;
  } sb_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   waits;
  int   mul_edge;
  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[0:8];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  alu_exec_if #(.DATA_W(DATA_W)) bus ();

  alu_exec_unit #(.DATA_W(DATA_W)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  // Called at a falling edge; holds the request until ready_o, returns one cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push, output int n_wait);
    int lat;
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    n_wait = 0;
    while (bus.ready_o !== 1'b1 && n_wait < 40) begin
      @(negedge clk_i);
      n_wait++;
    end
    if (bus.ready_o !== 1'b1) begin
      check("accept_timeout", {31'b0, bus.ready_o}, 32'd1);
      bus.valid_i = 1'b0;
    end else begin
      lat = (op == 3'b100) ? DATA_W : 0;
      if (push) sb.push_back('{exp, cyc + 1 + lat});
      @(negedge clk_i);
    end
  endtask

  initial begin
    vecs[0] = '{3'b000, 32'h0000_000F, 32'h0000_0003, 32'h0000_0012};
    vecs[1] = '{3'b001, 32'h0000_000F, 32'h0000_0003, 32'h0000_000C};
    vecs[2] = '{3'b010, 32'h0000_000F, 32'h0000_0003, 32'h0000_0003};
    vecs[3] = '{3'b011, 32'h0000_000F, 32'h0000_0003, 32'h0000_000C};
    vecs[4] = '{3'b101, 32'h0000_000F, 32'h0000_0003, 32'h0000_0078};
    vecs[5] = '{3'b110, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[6] = '{3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
    vecs[7] = '{3'b101, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008};
    vecs[8] = '{3'b111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};

    rst_i = 1'b1;
    idle();
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = 32'h0;
    bus.data2_i   = 32'h0;

    // Scoreboard monitor: every valid_o must match the oldest expectation, value and cycle.
    fork
      forever begin
        @(posedge clk_i);
        #1;
        if (rst_i === 1'b0 && bus.valid_o === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", {31'b0, bus.valid_o}, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            check("result", bus.result_o, mon_e.res);
            check("zero_flag", {31'b0, bus.zero_o}, {31'b0, (mon_e.res == 32'h0)});
            check("latency", cyc, mon_e.due);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", {31'b0, bus.ready_o}, 32'd1);
    check("rst_valid", {31'b0, bus.valid_o}, 32'd0);
    check("rst_result", bus.result_o, 32'h0);
    check("rst_zero", {31'b0, bus.zero_o}, 32'd1);

    // Back-to-back single-cycle ops.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, waits);
    end
    idle();
    repeat (3) @(negedge clk_i);

    // MUL with an ADD held on valid_i through the busy window.
    issue(3'b100, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b1, waits);
    mul_edge = cyc;
    issue(3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b1, waits);
    idle();
    check("mul_busy_cycles", waits, 32'd32);
    check("held_add_accept_edge", cyc, mul_edge + 33);
    repeat (2) @(negedge clk_i);

    issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, waits);
    idle();

    // Flush ten cycles into a MUL (waits for the previous MUL to finish first).
    issue(3'b100, 32'h0000_0003, 32'h0000_0005, 32'h0, 1'b0, waits);
    idle();
    repeat (9) @(negedge clk_i);
    bus.flush_i = 1'b1;
    @(negedge clk_i);
    bus.flush_i = 1'b0;
    check("flush_ready", {31'b0, bus.ready_o}, 32'd1);
    check("flush_valid", {31'b0, bus.valid_o}, 32'd0);
    check("flush_result_held", bus.result_o, 32'h0000_0001);

    // Flush together with a request in IDLE: dropped.
    bus.valid_i   = 1'b1;
    bus.flush_i   = 1'b1;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = 32'h0000_0001;
    bus.data2_i   = 32'h0000_0001;
    @(negedge clk_i);
    idle();
    repeat (3) @(negedge clk_i);
    check("flush_idle_result_held", bus.result_o, 32'h0000_0001);
    check("flush_idle_ready", {31'b0, bus.ready_o}, 32'd1);

    // Asynchronous reset mid-MUL.
    issue(3'b100, 32'h0000_1234, 32'h0000_5678, 32'h0, 1'b0, waits);
    idle();
    repeat (4) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_ready", {31'b0, bus.ready_o}, 32'd1);
    check("async_rst_valid", {31'b0, bus.valid_o}, 32'd0);
    check("async_rst_result", bus.result_o, 32'h0);
    check("async_rst_zero", {31'b0, bus.zero_o}, 32'd1);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    issue(3'b000, 32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 1'b1, waits);
    idle();

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
